// File: rtl/mem_access.sv
// Memory-access pipeline stage.
// Sits between execute and writeback. Stores are issued to data memory in the
// cycle they are accepted. Loads take one extra cycle because the memory's
// read data arrives one cycle after the address. Everything else passes
// through one output register.
module mem_access #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              stall_o,
  input  logic              wb_i,
  input  logic [RD_W-1:0]   rd_num_i,
  input  logic [WORD_W-1:0] rd_data_i,
  input  logic [1:0]        mop_i,
  input  logic [WORD_W-1:0] st_data_i,
  input  logic              stall_i,
  output logic              v_o,
  output logic              wb_o,
  output logic [RD_W-1:0]   rd_num_o,
  output logic [WORD_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] dmem_a_o,
  output logic              dmem_w_o,
  output logic [WORD_W-1:0] dmem_d_o,
  input  logic [WORD_W-1:0] dmem_q_i
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LDWAIT = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              wb_reg;
  logic [RD_W-1:0]   rd_num_reg;
  logic [WORD_W-1:0] rd_data_reg;

  // Handshake and memory-port decode. Accept is gated by rst so that no
  // store strobe escapes during reset. The strobe only fires on a real
  // accept, so a stalled store is never written twice.
  always_comb begin
    is_load  = (mop_i == 2'b01);
    is_store = (mop_i == 2'b10);
    stall_o  = (state_reg == LDWAIT) || ((state_reg == FULL) && stall_i);
    accept   = v_i && !stall_o && !rst;
    dmem_w_o = accept && is_store;
    dmem_a_o = rd_data_i[ADDR_W-1:0];
    dmem_d_o = st_data_i;
    v_o      = (state_reg == FULL);
    wb_o     = wb_reg;
    rd_num_o = rd_num_reg;
    rd_data_o = rd_data_reg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. When FULL with no downstream stall, the stage can
  // drain and accept in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = is_load ? LDWAIT : FULL;
        end
      end
      LDWAIT: begin
        state_next = FULL;
      end
      FULL: begin
        if (!stall_i) begin
          if (accept) begin
            state_next = is_load ? LDWAIT : FULL;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Output registers. A store never writes back a register. A load keeps
  // its old data word until the memory result is captured in LDWAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg      <= 1'b0;
      rd_num_reg  <= '0;
      rd_data_reg <= '0;
    end else if (accept) begin
      wb_reg     <= wb_i && !is_store;
      rd_num_reg <= rd_num_i;
      if (!is_load) begin
        rd_data_reg <= rd_data_i;
      end
    end else if (state_reg == LDWAIT) begin
      rd_data_reg <= dmem_q_i;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access. Expected writeback entries go into a
// scoreboard queue as stimulus is driven. A monitor pops them when the DUT
// hands an entry to writeback (v_o=1 and stall_i=0).
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        v_i;
  logic        stall_o;
  logic        wb_i;
  logic [4:0]  rd_num_i;
  logic [31:0] rd_data_i;
  logic [1:0]  mop_i;
  logic [31:0] st_data_i;
  logic        stall_i;
  logic        v_o;
  logic        wb_o;
  logic [4:0]  rd_num_o;
  logic [31:0] rd_data_o;
  logic [15:0] dmem_a_o;
  logic        dmem_w_o;
  logic [31:0] dmem_d_o;
  logic [31:0] dmem_q_i;

  typedef struct packed {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  int          wr_cnt = 0;
  int          tests  = 0;
  int          fails  = 0;

  mem_access #(.ADDR_W(16), .WORD_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .wb_i(wb_i),
    .rd_num_i(rd_num_i), .rd_data_i(rd_data_i), .mop_i(mop_i),
    .st_data_i(st_data_i), .stall_i(stall_i), .v_o(v_o), .wb_o(wb_o),
    .rd_num_o(rd_num_o), .rd_data_o(rd_data_o), .dmem_a_o(dmem_a_o),
    .dmem_w_o(dmem_w_o), .dmem_d_o(dmem_d_o), .dmem_q_i(dmem_q_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with one-cycle read latency.
  always @(posedge clk) begin
    if (dmem_w_o === 1'b1) begin
      mem[dmem_a_o[7:0]] <= dmem_d_o;
      wr_cnt <= wr_cnt + 1;
    end
    dmem_q_i <= mem[dmem_a_o[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: one line per retired entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && v_o === 1'b1 && stall_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, v_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] retire rd=%0d wb=%0b data=%h", rd_num_o, wb_o, rd_data_o);
        chk("sb_wb", {31'd0, wb_o}, {31'd0, e.wb});
        chk("sb_rd", {27'd0, rd_num_o}, {27'd0, e.rd});
        chk("sb_data", rd_data_o, e.data);
      end
    end
  end

  task automatic idle();
    v_i   = 1'b0;
    mop_i = 2'b00;
    @(posedge clk); #1;
  endtask

  // Drive one entry that is expected to be accepted. Loads also spend
  // their LDWAIT cycle here.
  task automatic issue(input logic [1:0] mop, input logic wb, input logic [4:0] rd,
                       input logic [31:0] data, input logic [31:0] st);
    exp_t e;
    v_i = 1'b1; mop_i = mop; wb_i = wb; rd_num_i = rd; rd_data_i = data; st_data_i = st;
    e.rd = rd;
    if (mop == 2'b01) begin
      e.wb = wb; e.data = exp_mem[data[7:0]];
    end else begin
      e.wb = (mop == 2'b10) ? 1'b0 : wb; e.data = data;
    end
    exp_q.push_back(e);
    if (mop == 2'b10) exp_mem[data[7:0]] = st;
    @(negedge clk);
    chk("issue_stall_o", {31'd0, stall_o}, 32'd0);
    chk("issue_dmem_w", {31'd0, dmem_w_o}, {31'd0, (mop == 2'b10)});
    if (mop == 2'b10) begin
      chk("issue_dmem_a", {16'd0, dmem_a_o}, {16'd0, data[15:0]});
      chk("issue_dmem_d", dmem_d_o, st);
    end
    @(posedge clk); #1;
    if (mop == 2'b01) begin
      v_i = 1'b0;
      @(negedge clk);
      chk("ldwait_stall_o", {31'd0, stall_o}, 32'd1);
      chk("ldwait_v_o", {31'd0, v_o}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
      exp_mem[i] = 32'd0;
    end
    // Reset while a store is being offered: no strobe, outputs cleared.
    rst = 1'b1; v_i = 1'b1; mop_i = 2'b10; wb_i = 1'b1; rd_num_i = 5'd5;
    rd_data_i = 32'h10; st_data_i = 32'h55; stall_i = 1'b0;
    @(negedge clk);
    chk("rst_dmem_w", {31'd0, dmem_w_o}, 32'd0);
    @(posedge clk); #1;
    chk("rst_v_o", {31'd0, v_o}, 32'd0);
    chk("rst_wb_o", {31'd0, wb_o}, 32'd0);
    chk("rst_rd_num", {27'd0, rd_num_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    rst = 1'b0; v_i = 1'b0; mop_i = 2'b00;
    @(negedge clk);
    chk("post_rst_stall_o", {31'd0, stall_o}, 32'd0);
    chk("rst_no_write", wr_cnt, 32'd0);
    @(posedge clk); #1;

    // ALU pass-through, one-cycle latency.
    issue(2'b00, 1'b1, 5'd3, 32'h1234, 32'd0);
    chk("alu_v_o", {31'd0, v_o}, 32'd1);
    chk("alu_rd_data", rd_data_o, 32'h1234);
    idle();

    // Back-pressure with a store waiting on the input.
    issue(2'b00, 1'b1, 5'd1, 32'hAA, 32'd0);
    stall_i = 1'b1; v_i = 1'b1; mop_i = 2'b10; wb_i = 1'b1; rd_num_i = 5'd4;
    rd_data_i = 32'h20; st_data_i = 32'hCAFEF00D;
    w0 = wr_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_o", {31'd0, stall_o}, 32'd1);
      chk("bp_dmem_w", {31'd0, dmem_w_o}, 32'd0);
      chk("bp_v_o", {31'd0, v_o}, 32'd1);
      chk("bp_rd_data", rd_data_o, 32'hAA);
      @(posedge clk); #1;
    end
    chk("bp_no_write", wr_cnt, w0);
    stall_i = 1'b0;
    exp_q.push_back('{wb: 1'b0, rd: 5'd4, data: 32'h20});
    exp_mem[8'h20] = 32'hCAFEF00D;
    @(negedge clk);
    chk("bp_rel_stall_o", {31'd0, stall_o}, 32'd0);
    chk("bp_rel_dmem_w", {31'd0, dmem_w_o}, 32'd1);
    @(posedge clk); #1;
    v_i = 1'b0;
    chk("bp_one_write", wr_cnt, w0 + 1);
    idle();
    chk("bp_still_one_write", wr_cnt, w0 + 1);

    // Store then load of the same address, two-cycle load latency.
    issue(2'b10, 1'b1, 5'd2, 32'h10, 32'hDEADBEEF);
    issue(2'b01, 1'b1, 5'd7, 32'h10, 32'd0);
    chk("ld_v_o", {31'd0, v_o}, 32'd1);
    chk("ld_rd_num", {27'd0, rd_num_o}, 32'd7);
    chk("ld_rd_data", rd_data_o, 32'hDEADBEEF);

    // Back-to-back loads, drained and accepted together.
    issue(2'b01, 1'b1, 5'd8, 32'h20, 32'd0);
    issue(2'b01, 1'b1, 5'd9, 32'h10, 32'd0);
    issue(2'b01, 1'b0, 5'd10, 32'h30, 32'd0);
    idle();

    // Streaming ALU ops.
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 1'b1, 5'(11 + i), 32'h100 + i, 32'd0);
      chk("stream_v_o", {31'd0, v_o}, 32'd1);
    end
    idle();

    // Reserved op code behaves as no memory op.
    issue(2'b11, 1'b1, 5'd12, 32'h5, 32'h77);
    chk("mop11_rd_data", rd_data_o, 32'h5);
    idle();

    // Reset during LDWAIT discards the load.
    v_i = 1'b1; mop_i = 2'b01; wb_i = 1'b1; rd_num_i = 5'd13; rd_data_i = 32'h10;
    @(posedge clk); #1;
    v_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstld_v_o", {31'd0, v_o}, 32'd0);
    chk("rstld_rd_data", rd_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstld_stall_o", {31'd0, stall_o}, 32'd0);
    repeat (4) idle();
    chk("rstld_no_out", {31'd0, v_o}, 32'd0);

    idle();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
